// File: rtl/pending_encoder.sv
// Latches multi-hot request pulses into a pending set and issues them one at
// a time as binary indices, round-robin, over a valid/ready handshake.

module pending_lane (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic clr,
  output logic pend,
  output logic dup
);
  // A request landing on the bit being issued this edge re-arms it.
  always_ff @(posedge clk)
    if (rst) pend <= 1'b0;
    else     pend <= (pend & ~clr) | req;

  assign dup = req & pend & ~clr;
endmodule

module pending_encoder #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic [N-1:0]     pending,
  output logic             overflow
);
  logic [IDX_W-1:0] ptr;
  logic [N-1:0]     rot, clr_mask, dup;
  logic [IDX_W-1:0] sel;
  logic             hit, load;

  assign load = !out_valid || out_ready;

  // Rotate pending by ptr, take the lowest set bit, rotate the index back.
  always_comb begin
    int j;
    j   = 0;
    hit = 1'b0;
    for (int i = 0; i < N; i++)
      rot[i] = pending[(i + int'(ptr)) % N];
    for (int i = N - 1; i >= 0; i--)
      if (rot[i]) begin
        hit = 1'b1;
        j   = i;
      end
    sel = IDX_W'((j + int'(ptr)) % N);
  end

  always_comb begin
    clr_mask = '0;
    if (load && hit) clr_mask[sel] = 1'b1;
  end

  for (genvar g = 0; g < N; g++) begin : g_lane
    pending_lane u_lane (
      .clk  (clk),
      .rst  (rst),
      .req  (req_in[g]),
      .clr  (clr_mask[g]),
      .pend (pending[g]),
      .dup  (dup[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
      ptr       <= '0;
      overflow  <= 1'b0;
    end else begin
      overflow <= |dup;
      if (load) begin
        out_valid <= hit;
        if (hit) begin
          out_idx <= sel;
          ptr     <= IDX_W'((int'(sel) + 1) % N);
        end
      end
    end
  end
endmodule

// File: tb/tb_pending_encoder.sv
// Randomized and directed bench for pending_encoder against a set-based model.

module tb_pending_encoder;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req_in;
  logic       out_ready;
  logic       out_valid;
  logic [2:0] out_idx;
  logic [7:0] pending;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  bit go = 1'b0;

  pending_encoder #(.N(8), .IDX_W(3)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .out_ready(out_ready),
    .out_valid(out_valid), .out_idx(out_idx), .pending(pending), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference model: pending set as a bit array, search walks upward from ptr.
  bit       m_pend[8];
  bit       m_valid, m_ovf;
  int       m_idx, m_ptr;

  always @(posedge clk) begin
    if (rst) begin
      foreach (m_pend[k]) m_pend[k] = 1'b0;
      m_valid = 1'b0; m_idx = 0; m_ptr = 0; m_ovf = 1'b0;
    end else begin
      bit ld, found;
      int k, win;
      ld = !m_valid || out_ready;
      found = 1'b0; win = -1;
      if (ld)
        for (int s = 0; s < 8 && !found; s++) begin
          k = (m_ptr + s) % 8;
          if (m_pend[k]) begin found = 1'b1; win = k; end
        end
      m_ovf = 1'b0;
      for (int b = 0; b < 8; b++)
        if (req_in[b] && m_pend[b] && b != win) m_ovf = 1'b1;
      if (found) m_pend[win] = 1'b0;
      for (int b = 0; b < 8; b++)
        if (req_in[b]) m_pend[b] = 1'b1;
      if (ld) begin
        m_valid = found;
        if (found) begin m_idx = win; m_ptr = (win + 1) % 8; end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int model_pend();
    int v = 0;
    for (int b = 0; b < 8; b++) if (m_pend[b]) v |= (1 << b);
    return v;
  endfunction

  always @(negedge clk) if (go) begin
    chk("model_valid",   int'(out_valid), int'(m_valid));
    chk("model_idx",     int'(out_idx),   m_idx);
    chk("model_pending", int'(pending),   model_pend());
    chk("model_ovf",     int'(overflow),  int'(m_ovf));
  end

  task automatic step(input logic [7:0] r);
    req_in = r;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; req_in = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_in = '0; out_ready = 1'b1;
    @(negedge clk);
    go = 1'b1;
    chk("reset_valid", int'(out_valid), 0);
    chk("reset_idx",   int'(out_idx),   0);
    chk("reset_pend",  int'(pending),   0);
    chk("reset_ovf",   int'(overflow),  0);
    rst = 1'b0;

    // single request, two-edge latency
    step(8'h20);
    chk("t1_pend", int'(pending), 'h20);
    chk("t1_v0",   int'(out_valid), 0);
    step(8'h00);
    chk("t1_v1",   int'(out_valid), 1);
    chk("t1_idx",  int'(out_idx),   5);
    chk("t1_pend0", int'(pending),  0);
    step(8'h00);
    chk("t1_vend", int'(out_valid), 0);

    // full burst drains in index order
    do_reset();
    step(8'hFF);
    chk("t2_pend", int'(pending), 'hFF);
    for (int i = 0; i < 8; i++) begin
      step(8'h00);
      chk("t2_idx",  int'(out_idx),   i);
      chk("t2_v",    int'(out_valid), 1);
      chk("t2_pend", int'(pending),   (32'hFF << (i + 1)) & 32'hFF);
    end
    step(8'h00);
    chk("t2_vend", int'(out_valid), 0);

    // backpressure holds the index
    do_reset();
    out_ready = 1'b0;
    step(8'h14);
    step(8'h00);
    for (int i = 0; i < 5; i++) begin
      step(8'h00);
      chk("t3_hold_idx", int'(out_idx),   2);
      chk("t3_hold_v",   int'(out_valid), 1);
    end
    out_ready = 1'b1;
    step(8'h00);
    chk("t3_next", int'(out_idx), 4);
    step(8'h00);
    chk("t3_vend", int'(out_valid), 0);

    // round-robin wrap
    do_reset();
    step(8'h40);
    step(8'h00);
    chk("t4_six", int'(out_idx), 6);
    step(8'h82);
    step(8'h00);
    chk("t4_seven", int'(out_idx), 7);
    step(8'h00);
    chk("t4_one", int'(out_idx), 1);
    step(8'h09);
    step(8'h00);
    chk("t4_three", int'(out_idx), 3);
    step(8'h00);
    chk("t4_zero", int'(out_idx), 0);

    // duplicate request merges and pulses overflow
    do_reset();
    out_ready = 1'b0;
    step(8'h09);
    step(8'h00);
    chk("t5_hold0", int'(out_idx), 0);
    step(8'h08);
    chk("t5_ovf1", int'(overflow), 1);
    chk("t5_pend", int'(pending), 'h08);
    step(8'h00);
    chk("t5_ovf0", int'(overflow), 0);
    out_ready = 1'b1;
    step(8'h00);
    chk("t5_idx3", int'(out_idx), 3);
    step(8'h00);
    chk("t5_once", int'(out_valid), 0);

    // re-request on the loading edge re-issues without overflow
    do_reset();
    step(8'h08);
    step(8'h08);
    chk("t6_idx",  int'(out_idx),  3);
    chk("t6_pend", int'(pending),  'h08);
    chk("t6_ovf",  int'(overflow), 0);
    step(8'h00);
    chk("t6_again", int'(out_idx), 3);
    chk("t6_v",     int'(out_valid), 1);
    step(8'h00);
    chk("t6_vend", int'(out_valid), 0);

    // reset mid-operation
    do_reset();
    out_ready = 1'b0;
    step(8'hA5);
    step(8'hA5);
    chk("t7_pre_pend", int'(pending), 'hA5);
    chk("t7_pre_v",    int'(out_valid), 1);
    rst = 1'b1;
    step(8'hFF);
    rst = 1'b0;
    chk("t7_pend", int'(pending),   0);
    chk("t7_v",    int'(out_valid), 0);
    chk("t7_idx",  int'(out_idx),   0);
    chk("t7_ovf",  int'(overflow),  0);
    out_ready = 1'b1;
    step(8'h00);
    chk("t7_quiet", int'(out_valid), 0);
    step(8'h81);
    step(8'h00);
    chk("t7_ptr0", int'(out_idx), 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 249) == 0);
      step(8'($urandom & $urandom));
    end
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (12) step(8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
